// File: rtl/apb4_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : apb4_slave_mem
//  Description : APB4 slave exposing a DEPTH x DATA_WIDTH word memory with
//                byte-lane writes, programmable wait states, transfer error
//                detection (misaligned / out-of-range / read with strobes)
//                and a saturating error counter.
//  Ports       : PCLK, PRESET          - clock, synchronous active-high reset
//                PSEL, PENABLE, PWRITE - APB control
//                PADDR, PWDATA, PSTRB  - APB address, write data, byte lanes
//                PRDATA, PREADY        - read data, transfer complete
//                PSLVERR               - transfer error
//                ps                    - FSM state (IDLE=0, SETUP=1, ACCESS=2)
//                err_cnt               - saturating count of error transfers
//  Revision    : 1.0 - initial release
// ============================================================================
module apb4_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,   // 8, 16, 32 or 64
    parameter int DEPTH       = 64,   // >= 2
    parameter int WAIT_STATES = 0     // 0..15
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [1:0]              ps,
    output logic [7:0]              err_cnt
);

    localparam int c_NB  = DATA_WIDTH / 8;
    localparam int c_OFF = $clog2(c_NB);
    localparam int c_IW  = ADDR_WIDTH - c_OFF;
    localparam int c_MW  = $clog2(DEPTH);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;

    localparam logic [c_IW-1:0] c_DEPTH_IDX = c_IW'(DEPTH);

    logic [1:0]            r_ps;
    logic [1:0]            w_ns;
    logic [3:0]            r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_err_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [c_IW-1:0]       w_index;
    logic [c_MW-1:0]       w_mem_idx;
    logic                  w_misaligned;
    logic                  w_oob;
    logic                  w_err;
    logic                  w_complete;
    logic                  w_commit_wr;

    // ------------------------------------------------------------------
    // Address decode, always from the copy of PADDR captured in SETUP
    // ------------------------------------------------------------------
    assign w_index   = r_addr[ADDR_WIDTH-1:c_OFF];
    assign w_mem_idx = w_index[c_MW-1:0];

    generate
        if (c_OFF == 0) begin : g_no_offset
            assign w_misaligned = 1'b0;
        end else begin : g_offset
            assign w_misaligned = |r_addr[c_OFF-1:0];
        end
    endgenerate

    assign w_oob = (w_index >= c_DEPTH_IDX);

    // A read carrying byte strobes is treated as a malformed transfer.
    assign w_err = w_misaligned | w_oob | (~PWRITE & (|PSTRB));

    // Completion is suppressed while reset is held so that a transfer
    // caught by reset neither commits nor counts as an error.
    assign w_complete  = (r_ps == c_ACCESS) && (r_wait_cnt == 4'd0) &&
                         PSEL && PENABLE && !PRESET;
    assign w_commit_wr = w_complete && PWRITE && !w_err;

    // ------------------------------------------------------------------
    // FSM: state register (also owns the wait counter)
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_ps       <= c_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_ps <= w_ns;
            if (r_ps == c_SETUP) begin
                r_wait_cnt <= 4'(WAIT_STATES);
            end else if ((r_ps == c_ACCESS) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_ns = r_ps;
        case (r_ps)
            c_IDLE: begin
                // PENABLE without a fresh setup phase is ignored here.
                if (PSEL && !PENABLE) begin
                    w_ns = c_SETUP;
                end
            end
            c_SETUP: begin
                w_ns = c_ACCESS;
            end
            c_ACCESS: begin
                if (!PSEL) begin
                    // Master abandoned the transfer.
                    w_ns = c_IDLE;
                end else if ((r_wait_cnt == 4'd0) && PENABLE) begin
                    // Completion cycle; PENABLE is high here, so a
                    // following setup phase is picked up from IDLE.
                    w_ns = c_IDLE;
                end else begin
                    w_ns = c_ACCESS;
                end
            end
            default: begin
                w_ns = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        PREADY  = w_complete;
        PSLVERR = w_complete && w_err;
        PRDATA  = '0;
        if (w_complete && !PWRITE && !w_err) begin
            PRDATA = r_mem[w_mem_idx];
        end
    end

    assign ps      = r_ps;
    assign err_cnt = r_err_cnt;

    // ------------------------------------------------------------------
    // Address capture
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_addr <= '0;
        end else if (r_ps == c_SETUP) begin
            r_addr <= PADDR;
        end
    end

    // ------------------------------------------------------------------
    // Saturating error counter
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_err_cnt <= 8'd0;
        end else if (w_complete && w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Memory array; writes land only on the completion edge
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit_wr) begin
            for (int b = 0; b < c_NB; b++) begin
                if (PSTRB[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= PWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
